// File: rtl/nf10_mac_learning_lookup.sv
// Destination lookup stage: learns {source MAC -> source port} from first beats and
// writes the one-hot dst_port field of tuser, one-beat registered pipeline at full rate.
module nf10_mac_learning_lookup #(
   parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
   parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
   parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
   parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
   parameter int unsigned C_NUM_ENTRIES        = 4
) (
   input  logic                                 axi_aclk,
   input  logic                                 axi_reset,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
   input  logic                                 s_axis_tvalid,
   output logic                                 s_axis_tready,
   input  logic                                 s_axis_tlast,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tstrb,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
   output logic                                 m_axis_tvalid,
   input  logic                                 m_axis_tready,
   output logic                                 m_axis_tlast
);

   localparam int unsigned MAC_W  = 48;
   localparam int unsigned PORT_W = 8;
   localparam int unsigned IDX_W  = (C_NUM_ENTRIES > 1) ? $clog2(C_NUM_ENTRIES) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(C_NUM_ENTRIES - 1);
   localparam logic [PORT_W-1:0] PHYS_MASK = 8'h55;

   typedef enum logic [0:0] {WAIT_SOP, IN_PKT} state_t;

   state_t state_q, state_d;
   logic   first_beat;
   logic   accept;

   logic [C_NUM_ENTRIES-1:0] tbl_valid_q;
   logic [MAC_W-1:0]         tbl_mac_q  [C_NUM_ENTRIES];
   logic [PORT_W-1:0]        tbl_port_q [C_NUM_ENTRIES];
   logic [IDX_W-1:0]         ptr_q;

   logic [MAC_W-1:0]  da, sa;
   logic [PORT_W-1:0] src_port;
   logic              da_hit, sa_hit;
   logic [PORT_W-1:0] da_port;
   logic [IDX_W-1:0]  sa_idx;
   logic [PORT_W-1:0] dst_port;
   logic              learn_en;
   logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser_mod;

   assign s_axis_tready = ~axi_reset & (~m_axis_tvalid | m_axis_tready);
   assign accept        = s_axis_tvalid & s_axis_tready;

   assign da       = s_axis_tdata[MAC_W-1:0];
   assign sa       = s_axis_tdata[2*MAC_W-1:MAC_W];
   assign src_port = s_axis_tuser[23:16];

   // Packet framing state register
   always_ff @(posedge axi_aclk) begin
      if (axi_reset) state_q <= WAIT_SOP;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      first_beat = 1'b0;
      case (state_q)
         WAIT_SOP: begin
            first_beat = 1'b1;
            if (accept && !s_axis_tlast) state_d = IN_PKT;
         end
         IN_PKT: begin
            if (accept && s_axis_tlast) state_d = WAIT_SOP;
         end
         default: state_d = WAIT_SOP;
      endcase
   end

   // CAM search for DA and SA against the table as it stood before this edge
   always_comb begin
      da_hit  = 1'b0;
      da_port = '0;
      sa_hit  = 1'b0;
      sa_idx  = '0;
      for (int i = 0; i < C_NUM_ENTRIES; i++) begin
         if (tbl_valid_q[i] && (tbl_mac_q[i] == da)) begin
            da_hit  = 1'b1;
            da_port = tbl_port_q[i];
         end
         if (tbl_valid_q[i] && (tbl_mac_q[i] == sa)) begin
            sa_hit = 1'b1;
            sa_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      dst_port = PHYS_MASK & ~src_port;
      if (!da[0] && da_hit) begin
         if (da_port == src_port) dst_port = '0;
         else                     dst_port = da_port;
      end
   end

   always_comb begin
      tuser_mod = s_axis_tuser;
      if (first_beat) tuser_mod[31:24] = dst_port;
   end

   // Multicast sources and the null port are never learned
   assign learn_en = accept & first_beat & ~sa[0] & (src_port != '0);

   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         tbl_valid_q <= '0;
         ptr_q       <= '0;
      end else if (learn_en && !sa_hit) begin
         tbl_valid_q[ptr_q] <= 1'b1;
         ptr_q              <= (ptr_q == LAST_IDX) ? '0 : ptr_q + IDX_W'(1);
      end
   end

   // Table payload needs no reset; entries are qualified by tbl_valid_q
   always_ff @(posedge axi_aclk) begin
      if (learn_en) begin
         if (sa_hit) begin
            tbl_port_q[sa_idx] <= src_port;
         end else begin
            tbl_mac_q[ptr_q]  <= sa;
            tbl_port_q[ptr_q] <= src_port;
         end
      end
   end

   // Output register stage
   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tstrb  <= '0;
         m_axis_tuser  <= '0;
         m_axis_tlast  <= 1'b0;
      end else if (accept) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tdata  <= C_M_AXIS_DATA_WIDTH'(s_axis_tdata);
         m_axis_tstrb  <= (C_M_AXIS_DATA_WIDTH/8)'(s_axis_tstrb);
         m_axis_tuser  <= C_M_AXIS_TUSER_WIDTH'(tuser_mod);
         m_axis_tlast  <= s_axis_tlast;
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

endmodule
